// File: rtl/fnd_share_arbiter.sv
// Round-robin arbiter that lets three requesters share one FND display.
// The owner keeps the display for at least DWELL_CYCLES cycles unless it releases it first.
module fnd_share_arbiter #(
    parameter int DWELL_CYCLES = 1000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [2:0]  req,
    input  logic [41:0] req_data,
    input  logic [11:0] req_dp,
    output logic [2:0]  gnt,
    output logic        FCR,
    output logic [13:0] FDR,
    output logic [3:0]  FPR,
    output logic        busy
);

    localparam int CW = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL_CYCLES);
    localparam logic [13:0]   FDR_MAX   = 14'd9999;

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state, state_nx;
    logic [1:0]    last, last_nx;
    logic [CW-1:0] dwell, dwell_nx;
    logic [2:0]    gnt_nx;
    logic          fcr_nx;
    logic [13:0]   fdr_nx;
    logic [3:0]    fpr_nx;

    logic [13:0]   slice_data [4];
    logic [3:0]    slice_dp   [4];
    logic [2:0]    cand;
    logic [1:0]    c1, c2, c3, pick;
    logic          pick_ok;

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [13:0] clamp(input logic [13:0] d);
        return (d > FDR_MAX) ? FDR_MAX : d;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            slice_data[i] = req_data[14*i +: 14];
            slice_dp[i]   = req_dp[4*i +: 4];
        end
        slice_data[3] = '0;
        slice_dp[3]   = '0;
    end

    // While owning, the owner itself is excluded so the search only finds challengers.
    assign cand = (state == IDLE) ? req : (req & ~gnt);
    assign c1   = inc3(last);
    assign c2   = inc3(c1);
    assign c3   = inc3(c2);

    always_comb begin
        pick    = c1;
        pick_ok = 1'b1;
        if (cand[c1])      pick = c1;
        else if (cand[c2]) pick = c2;
        else if (cand[c3]) pick = c3;
        else               pick_ok = 1'b0;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_nx = state;
        last_nx  = last;
        dwell_nx = dwell;
        gnt_nx   = gnt;
        fcr_nx   = FCR;
        fdr_nx   = FDR;
        fpr_nx   = FPR;
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_nx = OWN;
                    last_nx  = pick;
                    dwell_nx = '0;
                    gnt_nx   = 3'b001 << pick;
                    fcr_nx   = 1'b1;
                end else begin
                    gnt_nx = '0;
                    fcr_nx = 1'b0;
                end
            end
            OWN: begin
                if (!req[last] || (dwell == DWELL_MAX && pick_ok)) begin
                    if (pick_ok) begin
                        last_nx  = pick;
                        dwell_nx = '0;
                        gnt_nx   = 3'b001 << pick;
                        fdr_nx   = clamp(slice_data[pick]);
                        fpr_nx   = slice_dp[pick];
                    end else begin
                        state_nx = IDLE;
                        dwell_nx = '0;
                        gnt_nx   = '0;
                        fcr_nx   = 1'b0;
                    end
                end else begin
                    if (dwell != DWELL_MAX) dwell_nx = dwell + 1'b1;
                    fdr_nx = clamp(slice_data[last]);
                    fpr_nx = slice_dp[last];
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            // NOTE: synchronous reset; last=2 makes requester 0 the first in search order.
            state <= IDLE;
            last  <= 2'd2;
            dwell <= '0;
            gnt   <= '0;
            FCR   <= 1'b0;
            FDR   <= '0;
            FPR   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            dwell <= dwell_nx;
            gnt   <= gnt_nx;
            FCR   <= fcr_nx;
            FDR   <= fdr_nx;
            FPR   <= fpr_nx;
            busy  <= (state_nx == OWN);
        end
    end

endmodule

// File: tb/tb_fnd_share_arbiter.sv
// Self-checking bench for fnd_share_arbiter: a behavioural model pushes expected
// outputs into a scoreboard queue each cycle and they are compared after the edge.
module tb_fnd_share_arbiter;

    localparam int DWELL = 4;

    logic        PCLK;
    logic        PRESET;
    logic [2:0]  req;
    logic [41:0] req_data;
    logic [11:0] req_dp;
    logic [2:0]  gnt;
    logic        FCR;
    logic [13:0] FDR;
    logic [3:0]  FPR;
    logic        busy;

    fnd_share_arbiter #(.DWELL_CYCLES(DWELL)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .req      (req),
        .req_data (req_data),
        .req_dp   (req_dp),
        .gnt      (gnt),
        .FCR      (FCR),
        .FDR      (FDR),
        .FPR      (FPR),
        .busy     (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [2:0]  gnt;
        logic        fcr;
        logic [13:0] fdr;
        logic [3:0]  fpr;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit          m_own;
    int          m_last;
    int          m_dwell;
    logic [2:0]  m_gnt;
    logic        m_fcr;
    logic [13:0] m_fdr;
    logic [3:0]  m_fpr;

    int wait_cnt [3];
    int max_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int from, input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (from + k) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [13:0] val_of(input logic [41:0] d, input int i);
        logic [13:0] v;
        v = 14'((d >> (14 * i)) & 42'h3fff);
        return (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    function automatic logic [3:0] dp_of(input logic [11:0] d, input int i);
        return 4'((d >> (4 * i)) & 12'hf);
    endfunction

    task automatic model_edge();
        int p;
        logic [2:0] others;
        if (PRESET) begin
            m_own = 0; m_last = 2; m_dwell = 0;
            m_gnt = '0; m_fcr = 1'b0; m_fdr = '0; m_fpr = '0;
        end else if (!m_own) begin
            p = rr_pick(m_last, req);
            if (p >= 0) begin
                m_own = 1; m_last = p; m_dwell = 0;
                m_gnt = 3'(1 << p); m_fcr = 1'b1;
            end else begin
                m_gnt = '0; m_fcr = 1'b0;
            end
        end else begin
            others = req & ~3'(1 << m_last);
            p = rr_pick(m_last, others);
            if (!req[m_last] || (m_dwell == DWELL && p >= 0)) begin
                if (p >= 0) begin
                    m_last = p; m_dwell = 0; m_gnt = 3'(1 << p);
                    m_fdr = val_of(req_data, p); m_fpr = dp_of(req_dp, p);
                end else begin
                    m_own = 0; m_dwell = 0; m_gnt = '0; m_fcr = 1'b0;
                end
            end else begin
                m_fdr = val_of(req_data, m_last);
                m_fpr = dp_of(req_dp, m_last);
                if (m_dwell < DWELL) m_dwell++;
            end
        end
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic step();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (req[i] && !gnt[i] && !PRESET) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
        model_edge();
        exp_q.push_back('{gnt: m_gnt, fcr: m_fcr, fdr: m_fdr, fpr: m_fpr, busy: m_own});
        @(posedge PCLK);
        #1;
        e = exp_q.pop_front();
        check("gnt",  32'(gnt),  32'(e.gnt));
        check("FCR",  32'(FCR),  32'(e.fcr));
        check("FDR",  32'(FDR),  32'(e.fdr));
        check("FPR",  32'(FPR),  32'(e.fpr));
        check("busy", 32'(busy), 32'(e.busy));
        check("onehot", 32'($countones(gnt) <= 1), 32'd1);
    endtask

    initial begin
        logic [2:0]  prev_gnt;
        int          run;
        logic [13:0] fdr_hold;

        PRESET = 1'b1; req = '0; req_data = '0; req_dp = '0;
        max_wait = 0;
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
        @(negedge PCLK);
        step();
        step();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_FDR", 32'(FDR), 32'd0);
        PRESET = 1'b0;

        // Three requesters, distinct values and dp masks
        req      = 3'b111;
        req_data = {14'd3333, 14'd2222, 14'd1111};
        req_dp   = {4'b0100, 4'b0010, 4'b0001};
        step();
        check("first_gnt",  32'(gnt),  32'b001);
        check("first_busy", 32'(busy), 32'd1);
        check("first_FCR",  32'(FCR),  32'd1);
        step();
        check("first_FDR", 32'(FDR), 32'd1111);
        prev_gnt = gnt;
        run = 2;
        for (int c = 0; c < 20; c++) begin
            step();
            check("nogap", 32'(gnt != 3'b000), 32'd1);
            if (gnt == prev_gnt) begin
                run++;
            end else begin
                check("hold5", 32'(run), 32'd5);
                check("rotate", 32'(gnt), 32'((prev_gnt == 3'b100) ? 3'b001 : (prev_gnt << 1)));
                run = 1;
                prev_gnt = gnt;
            end
        end

        // Sole requester 1 with an out-of-range value
        req      = 3'b010;
        req_data = {14'd0, 14'd12345, 14'd0};
        req_dp   = {4'b0000, 4'b0100, 4'b0000};
        for (int c = 0; c < 10; c++) step();
        check("sole_gnt", 32'(gnt), 32'b010);
        check("sole_FDR", 32'(FDR), 32'd9999);
        check("sole_FPR", 32'(FPR), 32'b0100);

        // Build owner 0 at dwell 1 with requester 2 waiting, then release
        req_data = {14'd700, 14'd500, 14'd300};
        req_dp   = {4'b1000, 4'b0100, 4'b0010};
        req = 3'b000; step();
        req = 3'b100; step();
        req = 3'b001; step();
        check("own0_gnt", 32'(gnt), 32'b001);
        req = 3'b101; step();
        req = 3'b100; step();
        check("dropA_gnt", 32'(gnt), 32'b100);
        check("dropA_FDR", 32'(FDR), 32'd700);
        fdr_hold = m_fdr;
        req = 3'b000; step();
        check("idle_gnt", 32'(gnt), 32'd0);
        check("idle_FCR", 32'(FCR), 32'd0);
        check("idle_FDR", 32'(FDR), 32'(fdr_hold));

        // Reset pulse during ownership
        req = 3'b010;
        for (int c = 0; c < 3; c++) step();
        PRESET = 1'b1; step();
        check("midrst_gnt",  32'(gnt),  32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_FDR",  32'(FDR),  32'd0);
        PRESET = 1'b0; step();
        check("postrst_gnt", 32'(gnt), 32'b010);

        // Randomised toggling
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
        max_wait = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(5) == 0) req[i] = ~req[i];
            req_data = {$urandom, $urandom} & {42{1'b1}};
            req_dp   = 12'($urandom);
            step();
        end
        check("fair_wait", 32'(max_wait <= 2 * (DWELL + 1)), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fnd_share_arbiter.md
FND_SHARE_ARBITER -- requirements
Module: fnd_share_arbiter

Interface
REQ-001 Parameter DWELL_CYCLES, default 1000: minimum number of cycles an owner keeps the display before preemption; the legal range SHALL be DWELL_CYCLES >= 1.
REQ-002 PCLK  input  1  single clock; all state SHALL update on the rising edge of PCLK.
REQ-003 PRESET  input  1  reset; reset SHALL be synchronous and active-high.
REQ-004 req  input  3  request from requesters 0..2; request i is held high while requester i wants the display.
REQ-005 req_data  input  42  display value from each requester; requester i drives bits [14i+13:14i].
REQ-006 req_dp  input  12  decimal-point mask from each requester; requester i drives bits [4i+3:4i].
REQ-007 gnt  output  3  one-hot grant; all zero when no requester owns the display.
REQ-008 FCR  output  1  display enable, driven to the FND controller.
REQ-009 FDR  output  14  display value, driven to the FND controller.
REQ-010 FPR  output  4  decimal-point mask, driven to the FND controller.
REQ-011 busy  output  1  high while in state OWN.

Function
REQ-012 The block SHALL have exactly two states: IDLE and OWN.
REQ-013 The block SHALL hold a 2-bit round-robin pointer last, equal to the index of the most recent owner.
REQ-014 Arbitration search order SHALL be last+1, last+2, last+3, all mod 3; the first index with req high wins.
REQ-015 In IDLE, when any req bit is high, the block SHALL go to OWN at the next edge, with gnt one-hot on the winner, last set to the winner, and the dwell counter set to 0.
REQ-016 In IDLE with req all zero, the block SHALL stay in IDLE with gnt=0 and FCR=0; FDR and FPR SHALL hold their last values.
REQ-017 In OWN, on every edge, FDR and FPR SHALL load from the owner's req_data and req_dp slices, giving exactly one cycle of latency.
REQ-018 In OWN, FCR SHALL be 1.
REQ-019 Any owner value greater than 9999 SHALL be clamped so that FDR = 9999 (14'd9999).
REQ-020 The dwell counter SHALL increment each cycle in OWN and saturate at DWELL_CYCLES; it SHALL never wrap.
REQ-021 Release condition A: the owner's req drops. At that edge, gnt SHALL move to the next requester in search order if one exists, otherwise the block SHALL go to IDLE with gnt=0.
REQ-022 Release condition A SHALL apply regardless of the dwell counter value.
REQ-023 Release condition B: the dwell counter equals DWELL_CYCLES and another req bit is high. At that edge, gnt SHALL move to the next requester in search order (preemption).
REQ-024 When no other requester is waiting, the owner SHALL keep the display indefinitely.
REQ-025 Every handoff SHALL be gapless: gnt switches directly between one-hot values, FCR stays 1, the dwell counter resets to 0, and last updates to the new owner.
REQ-026 On handoff, FDR and FPR at that edge SHALL load from the new owner's slices.
REQ-027 If the owner drops req in the same cycle that a preemption would occur, the result SHALL be identical to release condition A.
REQ-028 Request bits asserted while another requester owns the display SHALL only be serviced through REQ-021 or REQ-023.
REQ-029 gnt SHALL never have more than one bit set.
REQ-030 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-031 When PRESET is high at a rising edge, the block SHALL set state=IDLE, gnt=0, FCR=0, FDR=0, FPR=0, busy=0, dwell counter=0, and last=2, so that requester 0 has first priority.
REQ-032 PRESET asserted while in OWN SHALL abort ownership at that edge with the same values as REQ-031, and no grant SHALL be issued in the cycle PRESET is high.
REQ-033 In the first cycle after PRESET deasserts, the block SHALL behave as IDLE per REQ-015 and REQ-016.

Verification (DWELL_CYCLES=4)
REQ-034 Reset, then req=3'b111 -> after 1 edge gnt=001, busy=1, FCR=1; on the following edge FDR takes requester 0's value.
REQ-035 req=111 held for 20 cycles -> grant rotates 001→010→100→001, with each owner holding exactly 5 grant cycles and no cycle where gnt=0.
REQ-036 Sole requester 1 with req_data slice=12345 and req_dp slice=4'b0100, held for 10 cycles -> gnt stays 010, FDR=9999, FPR=0100.
REQ-037 Owner 0 drops req at dwell count 1 while req2 is high -> next edge gnt=100 with the dwell counter at 0; then req drops to 000 -> next edge IDLE, FCR=0, FDR unchanged.
REQ-038 PRESET pulsed for 1 cycle mid-ownership while req=010 -> all outputs 0 during reset; on the first edge after release gnt=010.
REQ-039 Randomized req toggling for 10k cycles -> gnt is always one-hot or zero, and no waiting requester waits longer than 2×(DWELL_CYCLES+1) cycles.
